mole_judge: RTL and testbench

MOLE_JUDGE -- requirements
Module: mole_judge

---
 rtl/mole_judge.sv | 133 +++++++++++++
 tb/tb_mole_judge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mole_judge.sv
// Whack-a-mole judge: shows one mole per round, scores hits, counts misses, ends the game at MAX_MISSES.
// All outputs are registered; a whack sampled at one edge is reflected in hit/miss/score/misses after that edge.
module mole_judge #(
    parameter int MOLE_TICKS = 4,
    parameter int GAP_TICKS  = 1,
    parameter int MAX_MISSES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic [15:0] mole_location,
    input  logic [15:0] whack,
    output logic [15:0] mole_display,
    output logic        hit,
    output logic        miss,
    output logic [7:0]  score,
    output logic [3:0]  misses,
    output logic        game_over
);

    localparam logic [3:0] MOLE_T = 4'(MOLE_TICKS);
    localparam logic [3:0] GAP_T  = 4'(GAP_TICKS);
    localparam logic [3:0] MAX_M  = 4'(MAX_MISSES);

    typedef enum logic [2:0] {IDLE, LOAD, SHOW, GAP, OVER} state_t;

    state_t      state, state_n;
    logic [15:0] mole, mole_n, disp_n;
    logic [3:0]  timer, timer_n, misses_n;
    logic [7:0]  score_n;
    logic        hit_n, miss_n;
    logic        loc_onehot, correct, wrong, expire;

    assign loc_onehot = (mole_location != 16'h0000) &&
                        ((mole_location & (mole_location - 16'h0001)) == 16'h0000);
    assign correct    = (whack & mole) != 16'h0000;
    assign wrong      = (whack != 16'h0000) && !correct;

    always_comb begin
        state_n  = state;
        mole_n   = mole;
        timer_n  = timer;
        score_n  = score;
        misses_n = misses;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        disp_n   = 16'h0000;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    score_n  = 8'd0;
                    misses_n = 4'd0;
                    state_n  = LOAD;
                end
            end
            LOAD: begin
                mole_n  = loc_onehot ? mole_location : 16'h0001;
                timer_n = MOLE_T;
                disp_n  = mole_n;
                state_n = SHOW;
            end
            SHOW: begin
                disp_n = mole;
                if (correct) begin
                    // A hit takes precedence over any tick or stray whack bits this cycle.
                    hit_n   = 1'b1;
                    score_n = (score == 8'hFF) ? score : score + 8'd1;
                    timer_n = GAP_T;
                    disp_n  = 16'h0000;
                    state_n = GAP;
                end else begin
                    expire = tick && (timer <= 4'd1);
                    if (tick && timer != 4'd0)
                        timer_n = timer - 4'd1;
                    if (wrong || expire) begin
                        miss_n   = 1'b1;
                        misses_n = misses + 4'd1;
                        if (misses_n == MAX_M) begin
                            disp_n  = 16'h0000;
                            state_n = OVER;
                        end else if (expire) begin
                            timer_n = GAP_T;
                            disp_n  = 16'h0000;
                            state_n = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    timer_n = (timer != 4'd0) ? timer - 4'd1 : 4'd0;
                    if (timer <= 4'd1)
                        state_n = LOAD;
                end
            end
            OVER: begin
                if (start) begin
                    score_n  = 8'd0;
                    misses_n = 4'd0;
                    state_n  = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mole         <= 16'h0000;
            timer        <= 4'd0;
            score        <= 8'd0;
            misses       <= 4'd0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            mole_display <= 16'h0000;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            mole         <= mole_n;
            timer        <= timer_n;
            score        <= score_n;
            misses       <= misses_n;
            hit          <= hit_n;
            miss         <= miss_n;
            mole_display <= disp_n;
            game_over    <= (state_n == OVER);
        end
    end

endmodule

// File: tb/tb_mole_judge.sv
// Directed game scenarios followed by random play, all checked against a phase-level model of the game.
module tb_mole_judge;

    localparam int MOLE_TICKS = 4;
    localparam int GAP_TICKS  = 1;
    localparam int MAX_MISSES = 3;

    localparam int P_IDLE = 0, P_LOAD = 1, P_SHOW = 2, P_GAP = 3, P_OVER = 4;

    logic        clk = 1'b0;
    logic        rst, start, tick;
    logic [15:0] mole_location, whack;
    logic [15:0] mole_display;
    logic        hit, miss, game_over;
    logic [7:0]  score;
    logic [3:0]  misses;

    int checks = 0;
    int errors = 0;

    int          m_phase, m_left, m_score, m_misses;
    logic [15:0] m_mole;
    bit          m_hit, m_miss;

    mole_judge #(
        .MOLE_TICKS(MOLE_TICKS),
        .GAP_TICKS (GAP_TICKS),
        .MAX_MISSES(MAX_MISSES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tick         (tick),
        .mole_location(mole_location),
        .whack        (whack),
        .mole_display (mole_display),
        .hit          (hit),
        .miss         (miss),
        .score        (score),
        .misses       (misses),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit s, input bit t,
                         input logic [15:0] loc, input logic [15:0] w);
        bit timeout;
        m_hit  = 0;
        m_miss = 0;
        if (r) begin
            m_phase = P_IDLE; m_mole = 0; m_left = 0; m_score = 0; m_misses = 0;
            return;
        end
        case (m_phase)
            P_IDLE, P_OVER: begin
                if (s) begin
                    m_score = 0; m_misses = 0; m_phase = P_LOAD;
                end
            end
            P_LOAD: begin
                m_mole  = ($countones(loc) == 1) ? loc : 16'h0001;
                m_left  = MOLE_TICKS;
                m_phase = P_SHOW;
            end
            P_SHOW: begin
                if ((w & m_mole) != 0) begin
                    m_hit   = 1;
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_left  = GAP_TICKS;
                    m_phase = P_GAP;
                end else begin
                    timeout = t && (m_left == 1);
                    if (t) m_left = m_left - 1;
                    if (w != 0 || timeout) begin
                        m_miss   = 1;
                        m_misses = m_misses + 1;
                        if (m_misses == MAX_MISSES) m_phase = P_OVER;
                        else if (timeout) begin
                            m_left  = GAP_TICKS;
                            m_phase = P_GAP;
                        end
                    end
                end
            end
            P_GAP: begin
                if (t) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = P_LOAD;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic step(input bit r, input bit s, input bit t,
                        input logic [15:0] loc, input logic [15:0] w);
        rst = r; start = s; tick = t; mole_location = loc; whack = w;
        @(posedge clk);
        model(r, s, t, loc, w);
        #1;
        chk("display",   32'(mole_display), 32'((m_phase == P_SHOW) ? m_mole : 16'h0000));
        chk("hit",       32'(hit),          32'(m_hit));
        chk("miss",      32'(miss),         32'(m_miss));
        chk("score",     32'(score),        32'(m_score));
        chk("misses",    32'(misses),       32'(m_misses));
        chk("game_over", 32'(game_over),    32'(m_phase == P_OVER));
        chk("hit_and_miss", 32'(hit & miss), 32'd0);
    endtask

    initial begin
        logic [15:0] loc_r, w_r;
        rst = 1'b1; start = 1'b0; tick = 1'b0; mole_location = 16'h0; whack = 16'h0;
        m_phase = P_IDLE; m_mole = 0; m_left = 0; m_score = 0; m_misses = 0;

        step(1, 0, 0, 16'h0, 16'h0);
        step(1, 0, 0, 16'h0, 16'h0);
        chk("reset_display", 32'(mole_display), 32'h0);
        chk("reset_score",   32'(score),        32'h0);

        // First mole at hole 6, whacked correctly
        step(0, 1, 0, 16'h0040, 16'h0);
        step(0, 0, 0, 16'h0040, 16'h0);
        chk("show_0040", 32'(mole_display), 32'h0040);
        step(0, 0, 0, 16'h0, 16'h0040);
        chk("hit_0040",   32'(hit),          32'h1);
        chk("score_1",    32'(score),        32'h1);
        chk("cleared",    32'(mole_display), 32'h0);

        // Timeout miss after MOLE_TICKS ticks
        step(0, 0, 1, 16'h0008, 16'h0);
        step(0, 0, 0, 16'h0008, 16'h0);
        chk("show_0008", 32'(mole_display), 32'h0008);
        for (int i = 0; i < MOLE_TICKS; i++) step(0, 0, 1, 16'h0, 16'h0);
        chk("timeout_miss", 32'(miss),   32'h1);
        chk("misses_1",     32'(misses), 32'h1);
        step(0, 0, 1, 16'h0008, 16'h0);
        step(0, 0, 0, 16'h0008, 16'h0);

        // Wrong whack keeps mole up, then multi-bit whack containing the mole hits
        step(0, 0, 0, 16'h0, 16'h0010);
        chk("wrong_miss", 32'(miss),         32'h1);
        chk("misses_2",   32'(misses),       32'h2);
        chk("still_up",   32'(mole_display), 32'h0008);
        step(0, 0, 0, 16'h0, 16'h0018);
        chk("multi_hit",  32'(hit),   32'h1);
        chk("multi_nomiss", 32'(miss), 32'h0);
        chk("score_2",    32'(score), 32'h2);

        // Non-one-hot location replaced by hole 0; third miss ends the game
        step(0, 0, 1, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0000, 16'h0);
        chk("zero_loc", 32'(mole_display), 32'h0001);
        step(0, 0, 0, 16'h0, 16'h0002);
        chk("game_over", 32'(game_over),    32'h1);
        chk("over_disp", 32'(mole_display), 32'h0);
        chk("over_score", 32'(score),       32'h2);
        step(0, 0, 1, 16'h0, 16'h0001);
        chk("over_hold", 32'(misses), 32'h3);
        step(0, 1, 0, 16'h0300, 16'h0);
        chk("restart_score", 32'(score),     32'h0);
        chk("restart_over",  32'(game_over), 32'h0);
        step(0, 0, 0, 16'h0300, 16'h0);
        chk("multi_loc", 32'(mole_display), 32'h0001);

        // Build score to 5, then reset with a simultaneous correct whack
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 16'h0001, 16'h0001);
            step(0, 0, 1, 16'h0001, 16'h0);
            step(0, 0, 0, 16'h0001, 16'h0);
        end
        chk("score_5", 32'(score), 32'd5);
        step(1, 0, 1, 16'h0001, 16'h0001);
        chk("rst_nohit", 32'(hit),   32'h0);
        chk("rst_score", 32'(score), 32'h0);

        // Score saturates at 255
        step(0, 1, 0, 16'h0001, 16'h0);
        step(0, 0, 0, 16'h0001, 16'h0);
        for (int i = 0; i < 260; i++) begin
            step(0, 0, 0, 16'h0001, 16'h0001);
            step(0, 0, 1, 16'h0001, 16'h0);
            step(0, 0, 0, 16'h0001, 16'h0);
        end
        chk("score_sat", 32'(score), 32'd255);

        // Random play
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       loc_r = 16'h0000;
                1:       loc_r = 16'($urandom);
                default: loc_r = 16'h0001 << $urandom_range(0, 15);
            endcase
            case ($urandom_range(0, 9))
                6, 7:    w_r = (m_phase == P_SHOW) ? (m_mole | (16'($urandom) & 16'h00F0))
                                                   : 16'h0001 << $urandom_range(0, 15);
                8:       w_r = 16'h0001 << $urandom_range(0, 15);
                9:       w_r = 16'($urandom);
                default: w_r = 16'h0000;
            endcase
            step($urandom_range(0, 149) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 2) == 0, loc_r, w_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
